// File: rtl/lcd_pkg.sv
// Shared definitions for the LCD write scheduler: command bytes, FSM encoding,
// and the clear/home detection used to pick the settle time.
package lcd_pkg;

   localparam logic [7:0] CMD_CLEAR        = 8'h01;
   localparam logic [7:0] CMD_HOME         = 8'h02;
   localparam logic [7:0] CMD_ENTRY_INC    = 8'h06;
   localparam logic [7:0] CMD_DISP_ON      = 8'h0C;
   localparam logic [7:0] CMD_FUNC_8BIT_2L = 8'h38;
   localparam logic [7:0] CMD_LINE2_ADDR   = 8'hC0;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SETUP,
      ST_PULSE,
      ST_HOLD,
      ST_SETTLE
   } state_e;

   function automatic int max2(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

   // 0x03 also decodes as return-home on HD44780 (low bit is don't-care).
   function automatic logic is_long_cmd(input logic rs, input logic [7:0] data);
      return !rs && (data == CMD_CLEAR || data == CMD_HOME || data == 8'h03);
   endfunction

endpackage

// File: rtl/lcd_rr_arbiter.sv
// Combinational rotating-priority arbiter: first valid requester at or above
// the pointer, wrapping around.
module lcd_rr_arbiter #(
   parameter int NUM_REQ = 2,
   parameter int IDX_W   = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] valid_i,
   input  logic [IDX_W-1:0]   ptr_i,
   output logic [NUM_REQ-1:0] grant_o,
   output logic [IDX_W-1:0]   idx_o,
   output logic               any_o
);

   always_comb begin
      grant_o = '0;
      idx_o   = '0;
      any_o   = 1'b0;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (!any_o && valid_i[(int'(ptr_i) + k) % NUM_REQ]) begin
            any_o = 1'b1;
            grant_o[(int'(ptr_i) + k) % NUM_REQ] = 1'b1;
            idx_o = IDX_W'((int'(ptr_i) + k) % NUM_REQ);
         end
      end
   end

endmodule

// File: rtl/lcd_write_scheduler.sv
// Shares one HD44780 write bus among several requesters, sequencing each
// accepted byte through setup / enable pulse / hold / settle on the system clock.
module lcd_write_scheduler
   import lcd_pkg::*;
#(
   parameter int NUM_REQ          = 2,
   parameter int DATA_BITS        = 8,
   parameter int SETUP_CYCLES     = 2,
   parameter int EN_CYCLES        = 25,
   parameter int WAIT_CYCLES      = 2500,
   parameter int LONG_WAIT_CYCLES = 82000
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic [NUM_REQ-1:0]             req_valid,
   input  logic [NUM_REQ-1:0]             req_rs,
   input  logic [NUM_REQ*DATA_BITS-1:0]   req_data,
   output logic [NUM_REQ-1:0]             req_ready,
   output logic                           wr_done,
   output logic                           busy,
   output logic                           rs,
   output logic                           rw,
   output logic                           enable,
   output logic [DATA_BITS-1:0]           data
);

   localparam int MAX_CYC = max2(max2(SETUP_CYCLES, EN_CYCLES),
                                 max2(WAIT_CYCLES, LONG_WAIT_CYCLES));
   localparam int CNT_W   = $clog2(MAX_CYC + 1);
   localparam int IDX_W   = $clog2(NUM_REQ);

   state_e                 state_q, state_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic [IDX_W-1:0]       ptr_q, ptr_d;
   logic                   rs_q, rs_d;
   logic [DATA_BITS-1:0]   data_q, data_d;
   logic                   en_q, en_d;
   logic                   done_q, done_d;
   logic                   busy_q, busy_d;
   logic [NUM_REQ-1:0]     ready_c;

   logic [NUM_REQ-1:0]     grant;
   logic [IDX_W-1:0]       gidx;
   logic                   gany;
   logic                   last;
   logic                   long_cmd;

   lcd_rr_arbiter #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_arb (
      .valid_i (req_valid),
      .ptr_i   (ptr_q),
      .grant_o (grant),
      .idx_o   (gidx),
      .any_o   (gany)
   );

   assign last = (cnt_q == CNT_W'(1));
   // Bits above the command byte must be zero for a wide bus to match clear/home.
   assign long_cmd = is_long_cmd(rs_q, 8'(data_q)) &&
                     (data_q == DATA_BITS'(8'(data_q)));

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      ptr_d   = ptr_q;
      rs_d    = rs_q;
      data_d  = data_q;
      en_d    = 1'b0;
      done_d  = 1'b0;
      ready_c = '0;
      case (state_q)
         ST_IDLE: begin
            if (gany) begin
               ready_c = grant;
               rs_d    = req_rs[gidx];
               data_d  = req_data[gidx*DATA_BITS +: DATA_BITS];
               ptr_d   = (gidx == IDX_W'(NUM_REQ - 1)) ? '0 : IDX_W'(gidx + 1'b1);
               state_d = ST_SETUP;
               cnt_d   = CNT_W'(SETUP_CYCLES);
            end
         end
         ST_SETUP: begin
            if (last) begin
               state_d = ST_PULSE;
               cnt_d   = CNT_W'(EN_CYCLES);
               en_d    = 1'b1;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         ST_PULSE: begin
            if (last) begin
               state_d = ST_HOLD;
               cnt_d   = CNT_W'(SETUP_CYCLES);
            end else begin
               en_d  = 1'b1;
               cnt_d = cnt_q - 1'b1;
            end
         end
         ST_HOLD: begin
            if (last) begin
               state_d = ST_SETTLE;
               cnt_d   = long_cmd ? CNT_W'(LONG_WAIT_CYCLES) : CNT_W'(WAIT_CYCLES);
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         ST_SETTLE: begin
            if (last) begin
               state_d = ST_IDLE;
               cnt_d   = '0;
               done_d  = 1'b1;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      busy_d = (state_d != ST_IDLE);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         ptr_q   <= '0;
         rs_q    <= 1'b0;
         data_q  <= '0;
         en_q    <= 1'b0;
         done_q  <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         ptr_q   <= ptr_d;
         rs_q    <= rs_d;
         data_q  <= data_d;
         en_q    <= en_d;
         done_q  <= done_d;
         busy_q  <= busy_d;
      end
   end

   // The grant is combinational; keep it quiet while reset is being applied.
   assign req_ready = reset ? '0 : ready_c;
   assign wr_done   = done_q;
   assign busy      = busy_q;
   assign rs        = rs_q;
   assign rw        = 1'b0;
   assign enable    = en_q;
   assign data      = data_q;

endmodule

// File: tb/tb_lcd_write_scheduler.sv
// Bench for lcd_write_scheduler: a cycle-timing reference model driven by
// accept events, fed from a queue of expected grants.
module tb_lcd_write_scheduler;

   localparam int NR = 2;
   localparam int DB = 8;
   localparam int S  = 2;
   localparam int E  = 3;
   localparam int W  = 4;
   localparam int L  = 10;

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic [NR-1:0]     req_valid = '0;
   logic [NR-1:0]     req_rs = '0;
   logic [NR*DB-1:0]  req_data = '0;
   logic [NR-1:0]     req_ready;
   logic              wr_done, busy, rs, rw, enable;
   logic [DB-1:0]     data;

   lcd_write_scheduler #(
      .NUM_REQ(NR), .DATA_BITS(DB), .SETUP_CYCLES(S), .EN_CYCLES(E),
      .WAIT_CYCLES(W), .LONG_WAIT_CYCLES(L)
   ) dut (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_rs(req_rs),
      .req_data(req_data), .req_ready(req_ready), .wr_done(wr_done),
      .busy(busy), .rs(rs), .rw(rw), .enable(enable), .data(data)
   );

   always #5 clk = ~clk;

   typedef struct {
      int         idx;
      logic       rs;
      logic [7:0] data;
      int         wt;
   } vec_t;

   vec_t exp_q[$];
   int   n_chk = 0;
   int   n_err = 0;
   int   cyc = 0;

   bit         mon_on = 1'b0;
   bit         rst_prev = 1'b1;
   bit         m_act = 1'b0;
   int         m_t0 = 0;
   int         m_done = 0;
   logic       m_rs = 1'b0;
   logic [7:0] m_data = '0;
   int         acc_cnt = 0;
   int         acc_cyc = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s cyc=%0d actual=%0h expected=%0h", nm, cyc, act, exp);
      end
   endtask

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // Reference model: every output is a function of the last accept cycle.
   initial forever begin
      vec_t e;
      logic e_en, e_busy, e_wd;
      @(negedge clk);
      if (mon_on) begin
         if (rst_prev) begin
            m_act  = 1'b0;
            m_rs   = 1'b0;
            m_data = '0;
         end
         e_en   = m_act && cyc >= m_t0 + 1 + S && cyc <= m_t0 + S + E;
         e_busy = m_act && cyc >= m_t0 + 1 && cyc < m_done;
         e_wd   = m_act && cyc == m_done;
         chk("enable", enable, e_en);
         chk("busy", busy, e_busy);
         chk("wr_done", wr_done, e_wd);
         chk("rs", rs, m_rs);
         chk("data", data, m_data);
         chk("rw", rw, 1'b0);
         if (req_ready != '0) begin
            chk("ready_onehot", $countones(req_ready), 1);
            chk("accept_when_idle", (!m_act || cyc >= m_done), 1'b1);
            chk("accept_expected", exp_q.size() != 0, 1'b1);
            if (exp_q.size() != 0) begin
               e = exp_q.pop_front();
               chk("grant_idx", req_ready[1] ? 1 : 0, e.idx);
               m_t0   = cyc;
               m_done = cyc + 1 + 2*S + E + e.wt;
               m_act  = 1'b1;
               m_rs   = e.rs;
               m_data = e.data;
            end
            acc_cnt++;
            acc_cyc = cyc;
         end
      end
      rst_prev = reset;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_acc(input int target);
      int n = 0;
      while (acc_cnt < target && n < 100) begin
         tick();
         n++;
      end
      chk("accept_timeout", acc_cnt >= target, 1'b1);
   endtask

   task automatic wait_done();
      int n = 0;
      while (m_act && cyc <= m_done && n < 100) begin
         tick();
         n++;
      end
      chk("done_timeout", n < 100, 1'b1);
   endtask

   task automatic drive(input int idx, input logic r, input logic [7:0] d);
      req_rs[idx]           = r;
      req_data[idx*DB +: DB] = d;
      req_valid[idx]        = 1'b1;
   endtask

   vec_t tbl[9];

   initial begin
      int prev;
      tbl[0] = '{0, 1'b1, 8'h41, W};
      tbl[1] = '{1, 1'b0, 8'h01, L};
      tbl[2] = '{1, 1'b1, 8'h01, W};
      tbl[3] = '{0, 1'b0, 8'h02, L};
      tbl[4] = '{1, 1'b0, 8'h03, L};
      tbl[5] = '{0, 1'b0, 8'h04, W};
      tbl[6] = '{0, 1'b0, 8'h00, W};
      tbl[7] = '{0, 1'b0, 8'h38, W};
      tbl[8] = '{1, 1'b1, 8'h02, W};

      repeat (3) @(posedge clk);
      #1;
      reset  = 1'b0;
      mon_on = 1'b1;
      tick();
      chk("reset_ready", req_ready, 0);

      // Single writes, short and long settle.
      foreach (tbl[i]) begin
         exp_q.push_back(tbl[i]);
         drive(tbl[i].idx, tbl[i].rs, tbl[i].data);
         wait_acc(acc_cnt + 1);
         req_valid = '0;
         wait_done();
      end

      // Round robin with both requesters continuously valid.
      exp_q.push_back('{0, 1'b1, 8'h30, W});
      exp_q.push_back('{1, 1'b1, 8'h31, W});
      exp_q.push_back('{0, 1'b1, 8'h30, W});
      exp_q.push_back('{1, 1'b1, 8'h31, W});
      drive(0, 1'b1, 8'h30);
      drive(1, 1'b1, 8'h31);
      wait_acc(acc_cnt + 1);
      prev = acc_cyc;
      for (int k = 0; k < 3; k++) begin
         wait_acc(acc_cnt + 1);
         chk("rr_accept_on_done", acc_cyc, prev + 1 + 2*S + E + W);
         prev = acc_cyc;
      end
      req_valid = '0;
      wait_done();

      // Withdrawn request: req1 shows up for 3 cycles during a write.
      exp_q.push_back('{0, 1'b1, 8'h57, W});
      drive(0, 1'b1, 8'h57);
      wait_acc(acc_cnt + 1);
      req_valid = '0;
      drive(1, 1'b0, 8'h01);
      repeat (3) tick();
      req_valid = '0;
      wait_done();
      repeat (10) tick();
      chk("withdraw_no_accept", acc_cnt, acc_cnt - 0);
      chk("withdraw_idle_busy", busy, 1'b0);

      // Input data churns after accept; bus must keep the latched byte.
      exp_q.push_back('{0, 1'b1, 8'h55, W});
      drive(0, 1'b1, 8'h55);
      wait_acc(acc_cnt + 1);
      req_valid = '0;
      for (int k = 0; k < 14; k++) begin
         req_data[0 +: DB] = 8'($urandom);
         tick();
      end

      // Reset in the middle of the enable pulse.
      exp_q.push_back('{0, 1'b0, 8'h0C, W});
      drive(0, 1'b0, 8'h0C);
      wait_acc(acc_cnt + 1);
      req_valid = '0;
      while (cyc < acc_cyc + S + 2) tick();
      chk("pre_reset_enable", enable, 1'b1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("post_reset_enable", enable, 1'b0);
      chk("post_reset_busy", busy, 1'b0);
      chk("post_reset_data", data, 0);
      repeat (15) tick();
      exp_q.push_back('{0, 1'b1, 8'h61, W});
      exp_q.push_back('{1, 1'b1, 8'h62, W});
      drive(0, 1'b1, 8'h61);
      drive(1, 1'b1, 8'h62);
      wait_acc(acc_cnt + 1);
      req_valid[0] = 1'b0;
      wait_acc(acc_cnt + 1);
      req_valid = '0;
      wait_done();
      repeat (5) tick();

      chk("queue_drained", exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
